// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared FSM state type, default widths and watchdog sizing for the APB bridge arbiter
package apb_arb_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;
  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
  localparam int DEF_TIMEOUT = 16;
  localparam int CNT_W = $clog2(DEF_TIMEOUT + 1);
  function automatic int cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; req[NREQ] and ptr in, any and winning idx out
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   idx
);
  logic          found;
  logic [IW:0]   j;
  always_comb begin
    any = |req;
    idx = '0;
    found = 1'b0;
    j = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = {1'b0, ptr} + (IW+1)'(i);
      j = (j >= (IW+1)'(NREQ)) ? j - (IW+1)'(NREQ) : j;
      if (!found && req[j[IW-1:0]]) begin
        found = 1'b1;
        idx = j[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/apb_bridge_arbiter.sv
// apb_bridge_arbiter: round-robin sharing of one AHB-to-APB bridge among NREQ requesters with a watchdog
// Ports: Hclk/Hreset (sync, active high); req/req_addr/req_write/req_wdata from requesters;
// gnt/done/err/rdata back to requesters; valid/Haddr/Hwrite/Hwdata to the bridge; Hreadyout/Prdata from it.
module apb_bridge_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             Hclk,
  input  logic             Hreset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ-1:0]  req_write,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic             err,
  output logic [DW-1:0]    rdata,
  output logic             valid,
  output logic [AW-1:0]    Haddr,
  output logic             Hwrite,
  output logic [DW-1:0]    Hwdata,
  input  logic             Hreadyout,
  input  logic [DW-1:0]    Prdata
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = cnt_w(TIMEOUT);
  state_t        state, nxt;
  logic [IW-1:0] ptr, owner, pick_idx;
  logic          pick_any;
  logic [CW-1:0] cnt;
  logic          ok, tmo;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req(req),
    .ptr(ptr),
    .any(pick_any),
    .idx(pick_idx)
  );

  // the first WAIT cycle can still see the bridge's idle-high ready, so it is ignored
  assign ok = Hreadyout && (cnt != '0);
  assign tmo = cnt == CW'(TIMEOUT);
  assign valid = state == ADDR;
  assign gnt = (state == IDLE) ? '0 : NREQ'(1) << owner;

  always_ff @(posedge Hclk)
    state <= Hreset ? IDLE : nxt;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: nxt = (pick_any && Hreadyout) ? ADDR : IDLE;
      ADDR: nxt = WAIT;
      WAIT: nxt = (ok || tmo) ? DONE : WAIT;
      DONE: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      ptr <= '0;
      owner <= '0;
      cnt <= '0;
      Haddr <= '0;
      Hwrite <= 1'b0;
      Hwdata <= '0;
      rdata <= '0;
      err <= 1'b0;
      done <= '0;
    end else begin
      done <= '0;
      if (state == IDLE && nxt == ADDR) begin
        owner <= pick_idx;
        Haddr <= req_addr[pick_idx*AW +: AW];
        Hwrite <= req_write[pick_idx];
        Hwdata <= req_wdata[pick_idx*DW +: DW];
      end
      if (state == ADDR)
        cnt <= '0;
      if (state == WAIT) begin
        if (ok) begin
          err <= 1'b0;
          if (!Hwrite)
            rdata <= Prdata;
          done <= NREQ'(1) << owner;
        end else if (tmo) begin
          err <= 1'b1;
          rdata <= '0;
          done <= NREQ'(1) << owner;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (state == DONE)
        ptr <= (owner == IW'(NREQ-1)) ? '0 : owner + 1'b1;
    end
  end
endmodule

// File: tb/tb_apb_bridge_arbiter.sv
// tb_apb_bridge_arbiter: directed and randomized transfers checked against a transaction-level model
module tb_apb_bridge_arbiter;
  localparam int N = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            Hclk = 1'b0;
  logic            Hreset = 1'b1;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_write;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt, done;
  logic            err, valid, Hwrite, Hreadyout;
  logic [DW-1:0]   rdata, Hwdata, Prdata;
  logic [AW-1:0]   Haddr;

  logic [AW-1:0]   a [N];
  logic            w [N];
  logic [DW-1:0]   d [N];
  logic            fix_pd;
  logic [DW-1:0]   pd_val;
  int total = 0, bad = 0, mptr = 0;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_addr[g*AW +: AW] = a[g];
    assign req_write[g] = w[g];
    assign req_wdata[g*DW +: DW] = d[g];
  end

  apb_bridge_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .req(req), .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata), .valid(valid),
    .Haddr(Haddr), .Hwrite(Hwrite), .Hwdata(Hwdata), .Hreadyout(Hreadyout), .Prdata(Prdata)
  );

  always #5 Hclk = ~Hclk;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++)
      if (m[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic rnd_vals();
    for (int i = 0; i < N; i++) begin
      a[i] = $urandom;
      w[i] = 1'($urandom_range(0, 1));
      d[i] = $urandom;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_valid"}, 64'(valid), 0);
    chk({tag, "_err"}, 64'(err), 0);
    chk({tag, "_rdata"}, 64'(rdata), 0);
    chk({tag, "_haddr"}, 64'(Haddr), 0);
    chk({tag, "_hwrite"}, 64'(Hwrite), 0);
    chk({tag, "_hwdata"}, 64'(Hwdata), 0);
  endtask

  // one transfer from an IDLE negedge; bridge holds ready low for lat WAIT cycles, idle ready low for stall cycles
  task automatic xfer(input logic [N-1:0] m, input int lat, input int stall, input int rst_at);
    int win, n, k, kend;
    logic [AW-1:0] ea;
    logic ew, eerr;
    logic [DW-1:0] ed, epd;
    req = m;
    Hreadyout = (stall == 0);
    win = pick(m, mptr);
    n = 0;
    do begin
      @(negedge Hclk);
      n++;
      if (n >= stall) Hreadyout = 1'b1;
    end while (!valid && n < stall + 4);
    chk("addr_latency", 64'(n), 64'(stall + 1));
    chk("addr_gnt", 64'(gnt), 64'(N'(1) << win));
    chk("addr_haddr", 64'(Haddr), 64'(a[win]));
    chk("addr_hwrite", 64'(Hwrite), 64'(w[win]));
    chk("addr_hwdata", 64'(Hwdata), 64'(d[win]));
    ea = a[win]; ew = w[win]; ed = d[win];
    kend = (lat > TO) ? TO : (lat < 1 ? 1 : lat);
    eerr = lat > TO;
    a[win] = $urandom; d[win] = $urandom; w[win] = ~w[win];
    req = N'($urandom);
    epd = '0;
    @(negedge Hclk);
    for (k = 0; k <= TO + 2; k++) begin
      chk("wait_valid", 64'(valid), 0);
      chk("wait_gnt", 64'(gnt), 64'(N'(1) << win));
      chk("wait_done", 64'(done), 0);
      chk("wait_haddr", 64'(Haddr), 64'(ea));
      chk("wait_hwdata", 64'({Hwrite, Hwdata}), 64'({ew, ed}));
      if (k == rst_at) begin
        Hreset = 1'b1;
        req = '0;
        @(negedge Hclk);
        Hreset = 1'b0;
        Hreadyout = 1'b1;
        chk_zero("midreset");
        mptr = 0;
        return;
      end
      Hreadyout = (k >= lat);
      Prdata = fix_pd ? pd_val : $urandom;
      epd = Prdata;
      @(negedge Hclk);
      if (done != '0) break;
    end
    chk("wait_len", 64'(k), 64'(kend));
    chk("done_onehot", 64'(done), 64'(N'(1) << win));
    chk("done_gnt", 64'(gnt), 64'(N'(1) << win));
    chk("done_err", 64'(err), 64'(eerr));
    if (eerr) chk("done_rdata_tmo", 64'(rdata), 0);
    else if (!ew) chk("done_rdata", 64'(rdata), 64'(epd));
    mptr = (win + 1) % N;
    req = '0;
    @(negedge Hclk);
    Hreadyout = 1'b1;
    chk("idle_done", 64'(done), 0);
    chk("idle_gnt", 64'(gnt), 0);
    chk("idle_valid", 64'(valid), 0);
  endtask

  initial begin
    req = '0; Hreadyout = 1'b1; Prdata = '0; fix_pd = 1'b0; pd_val = '0;
    rnd_vals();
    repeat (2) @(negedge Hclk);
    chk_zero("reset");
    Hreset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a[0] = 32'h2000_0000; d[0] = 32'hA5A5_A5A5; w[0] = 1'b1;
      a[1] = 32'h4000_0000; d[1] = 32'h5A5A_5A5A; w[1] = 1'b1;
      xfer(4'b0011, 2, 0, -1);
    end
    a[0] = 32'h1000_0000; w[0] = 1'b0;
    fix_pd = 1'b1; pd_val = 32'hDEAD_BEEF;
    xfer(4'b0001, 2, 0, -1);
    fix_pd = 1'b0;
    rnd_vals();
    xfer(4'b0100, 1, 0, -1);
    xfer(4'b1001, 3, 0, -1);
    xfer(4'b1001, 1, 0, -1);
    xfer(4'b0010, 1000, 0, -1);
    xfer(4'b0010, 0, 0, -1);
    w[2] = 1'b0;
    xfer(4'b0100, TO, 0, -1);
    xfer(4'b0010, 1, 0, -1);
    xfer(4'b0100, 1000, 0, 3);
    xfer(4'b0110, 2, 0, -1);
    repeat (40) begin
      rnd_vals();
      xfer(N'($urandom_range(1, 15)), $urandom_range(0, TO + 3), $urandom_range(0, 2), -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
